posit_mul_sequencer: RTL
========================

Name: posit_mul_sequencer

Overview:
- Control front-end for the bit-serial FP16 × posit (es=0) multiplier.
- Accepts a precision configuration plus parallel {activation, posit weight} jobs over valid/ready.
- Drives the multiplier's set/valid/w/act pins: configures precision, serializes each weight MSB-first and holds the activation stable.
- Captures the multiplier result on done and presents it downstream over a valid/ready output register.

Parameters:
- ACT_WIDTH, 16, activation width (FP16: 1 sign, 5 exponent, 10 mantissa)
- MAX_PREC, 8, widest posit weight supported; in_weight width
- TIMEOUT, 15, cycles to wait for mul_done after the last bit before flagging an error

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  precision load request
- cfg_precision  in  4  posit width, legal 2..MAX_PREC
- in_valid  in  1  job request
- in_ready  out  1  job accepted when in_valid&in_ready
- in_act  in  ACT_WIDTH  FP16 activation
- in_weight  in  MAX_PREC  posit weight, right-aligned (bits precision-1..0 used)
- mul_set  out  1  precision load strobe to multiplier
- mul_precision  out  4  precision to multiplier
- mul_valid  out  1  serial bit-valid to multiplier
- mul_w  out  1  serial weight bit
- mul_act  out  ACT_WIDTH  activation to multiplier
- mul_sign  in  1  multiplier result sign
- mul_exp  in  5  multiplier result exponent
- mul_mant  in  14  multiplier result mantissa (4.10 fixed point)
- mul_done  in  1  multiplier done
- mul_zero  in  1  multiplier zero flag
- mul_nar  in  1  multiplier NaR flag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_sign  out  1  captured result sign
- out_exp  out  5  captured result exponent
- out_mant  out  14  captured result mantissa
- out_zero  out  1  captured zero flag
- out_nar  out  1  captured NaR flag
- busy  out  1  state != IDLE
- err_cfg  out  1  sticky illegal-precision flag
- err_timeout  out  1  sticky done-timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; precision register 0 (unconfigured); in_ready 0.
- States: IDLE, CONFIG, SHIFT, WAIT, GAP.
- IDLE:
  - cfg_valid has priority over in_valid.
  - Legal cfg_valid: latch precision, clear err_cfg, go CONFIG.
  - Illegal cfg_valid (<2 or >MAX_PREC): set err_cfg; precision unchanged; stay IDLE.
  - in_ready = (state==IDLE) && precision!=0 && !cfg_valid && !out_valid.
  - On accept: latch act and weight, bit index = precision-1, go SHIFT.
- CONFIG: mul_set=1 for exactly one cycle with mul_precision = new value → IDLE. mul_precision holds the latched precision at all times.
- SHIFT:
  - mul_valid=1, mul_w = weight[index], one bit per cycle, MSB first; index decrements.
  - Exactly precision consecutive valid cycles, then WAIT.
  - mul_act stable from the first SHIFT cycle through capture.
- WAIT:
  - mul_valid=0. When mul_done=1, capture mul_sign/exp/mant/zero/nar into the output register, set out_valid, go GAP.
  - If TIMEOUT cycles elapse without mul_done: set err_timeout, flush (no out_valid), go GAP.
- GAP: one cycle, mul_valid=0, so the multiplier's bit counter returns to 0 before the next job → IDLE.
- Latency: accept at cycle T; first bit at T+1; last bit at T+precision; capture no earlier than T+precision+1. out_valid is registered, so it rises the cycle after capture.
- Output: out_* hold stable while out_valid && !out_ready; out_valid clears on handshake. Because in_ready requires !out_valid, a capture never overwrites an unconsumed result.
- err_cfg clears on the next legal cfg; err_timeout clears only on reset.
- Reset mid-job: everything returns to reset values immediately; mul_valid drops asynchronously; the partial job is discarded.
- Inputs are ignored outside the states above. cfg_valid during a job is ignored (not queued).

Test Plan:
- Reset, then cfg_precision=4 → mul_set high exactly one cycle with mul_precision=4; in_ready rises the cycle after CONFIG.
- precision=4, in_weight=0x0B, in_act=0x3C00 → mul_valid high 4 cycles, mul_w sequence 1,0,1,1, mul_act=0x3C00 throughout.
- Multiplier model asserts done with exp=15, mant=0x0400 → out_valid with out_exp=15, out_mant=0x0400. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0. Release: one handshake.
- cfg_precision=9, then 1 → err_cfg=1, no mul_set, precision stays 4. Then cfg_precision=8 → err_cfg=0, mul_set pulse, 8-bit job shifts 8 bits.
- mul_done held 0 → err_timeout set TIMEOUT cycles after the last bit, no out_valid, return to IDLE. Next job completes normally.
- Assert rst during the 3rd SHIFT bit → mul_valid=0 and outputs 0 immediately. precision=0, so in_ready stays 0 until a new cfg.

Source files
------------

// File: rtl/posit_mul_sequencer.sv
// posit_mul_sequencer: configures and feeds a bit-serial FP16 x posit multiplier, then buffers its result
module posit_mul_sequencer #(
  parameter int ACT_WIDTH = 16,
  parameter int MAX_PREC = 8,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_valid,
  input  logic [3:0] cfg_precision,
  input  logic in_valid,
  output logic in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [MAX_PREC-1:0] in_weight,
  output logic mul_set,
  output logic [3:0] mul_precision,
  output logic mul_valid,
  output logic mul_w,
  output logic [ACT_WIDTH-1:0] mul_act,
  input  logic mul_sign,
  input  logic [4:0] mul_exp,
  input  logic [13:0] mul_mant,
  input  logic mul_done,
  input  logic mul_zero,
  input  logic mul_nar,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sign,
  output logic [4:0] out_exp,
  output logic [13:0] out_mant,
  output logic out_zero,
  output logic out_nar,
  output logic busy,
  output logic err_cfg,
  output logic err_timeout
);
  localparam int IW = $clog2(MAX_PREC);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CONFIG, SHIFT, WAIT, GAP} state_t;
  state_t state, next;
  logic [3:0] prec;
  logic [ACT_WIDTH-1:0] act;
  logic [MAX_PREC-1:0] weight;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic cfg_legal, accept, capture, expire;
  assign cfg_legal = cfg_precision >= 4'd2 && {1'b0, cfg_precision} <= 5'(MAX_PREC);
  assign in_ready = state == IDLE && prec != 4'd0 && !cfg_valid && !out_valid;
  assign accept = in_valid && in_ready;
  assign capture = state == WAIT && mul_done;
  assign expire = state == WAIT && !mul_done && cnt == CW'(TIMEOUT - 1);
  assign mul_set = state == CONFIG;
  assign mul_valid = state == SHIFT;
  assign mul_w = mul_valid && weight[idx];
  assign mul_precision = prec;
  assign mul_act = act;
  assign busy = state != IDLE;
  // State register; reset drops mul_valid immediately since it decodes from state
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // Next-state: config wins over a job in IDLE, shifting ends on bit 0, WAIT ends on done or timeout
  always_comb begin
    next = state;
    case (state)
      IDLE: next = cfg_valid ? (cfg_legal ? CONFIG : IDLE) : (accept ? SHIFT : IDLE);
      CONFIG: next = IDLE;
      SHIFT: next = idx == '0 ? WAIT : SHIFT;
      WAIT: next = (mul_done || expire) ? GAP : WAIT;
      GAP: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // Datapath: precision/error flags, job latch, bit index, timeout counter and output register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prec <= '0;
      act <= '0;
      weight <= '0;
      idx <= '0;
      cnt <= '0;
      err_cfg <= 1'b0;
      err_timeout <= 1'b0;
      out_valid <= 1'b0;
      out_sign <= 1'b0;
      out_exp <= '0;
      out_mant <= '0;
      out_zero <= 1'b0;
      out_nar <= 1'b0;
    end else begin
      if (state == IDLE && cfg_valid) begin
        if (cfg_legal) begin
          prec <= cfg_precision;
          err_cfg <= 1'b0;
        end else err_cfg <= 1'b1;
      end
      if (accept) begin
        act <= in_act;
        weight <= in_weight;
        idx <= IW'(prec - 4'd1);
      end else if (state == SHIFT) idx <= idx - IW'(1);
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      if (expire) err_timeout <= 1'b1;
      if (capture) begin
        out_valid <= 1'b1;
        out_sign <= mul_sign;
        out_exp <= mul_exp;
        out_mant <= mul_mant;
        out_zero <= mul_zero;
        out_nar <= mul_nar;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule
